// File: rtl/rf_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundles the two writeback requester handshakes and the register-file write
// port that rf_wb_arbiter drives.
//   slave  modport : the arbiter (consumes requests, drives rdy* and wb port)
//   master modport : the requesters / register-file side
// Signals:
//   v0/dest0/data0/rdy0   port 0 request (EXE/WB pipeline result)
//   v1/dest1/data1/rdy1   port 1 request (multi-cycle / memory unit)
//   wb_en/dest_wb/result_wb  registered register-file write port
//   err_dest              one-cycle pulse for a dropped write to r15
// -----------------------------------------------------------------------------
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32
) ();
    logic              v0;
    logic [3:0]        dest0;
    logic [DATA_W-1:0] data0;
    logic              rdy0;
    logic              v1;
    logic [3:0]        dest1;
    logic [DATA_W-1:0] data1;
    logic              rdy1;
    logic              wb_en;
    logic [3:0]        dest_wb;
    logic [DATA_W-1:0] result_wb;
    logic              err_dest;

    modport slave (
        input  v0, dest0, data0, v1, dest1, data1,
        output rdy0, rdy1, wb_en, dest_wb, result_wb, err_dest
    );

    modport master (
        output v0, dest0, data0, v1, dest1, data1,
        input  rdy0, rdy1, wb_en, dest_wb, result_wb, err_dest
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between two writeback requesters.
// Port 0 has fixed priority; port 1 is protected from starvation by a wait
// counter that lets it override port 0 once it has been blocked MAX_WAIT cycles.
// Grants (rdy0/rdy1) are combinational; the write port is registered, so a
// grant in cycle N appears as wb_en/dest_wb/result_wb in cycle N+1.
// Ports:
//   clk    system clock, all state on posedge
//   rst    synchronous active-high reset
//   stall  freeze: no grants while high
//   bus    rf_wb_arbiter_if.slave (requests, grants, register-file write port)
// Parameters:
//   DATA_W    writeback data width
//   MAX_WAIT  cycles port 1 may be blocked before it overrides port 0 (1..15)
// Configuration macro:
//   RF_ARB_DEST_GUARD_EN  when defined, a granted write to r15 is consumed but
//                         not issued; err_dest pulses instead. When undefined,
//                         r15 writes pass through and err_dest is tied low.
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    rf_wb_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [3:0] DEST_NONE  = 4'd15;

    logic [3:0]        wait1_r;
    logic              g0_s;
    logic              g1_s;
    logic              grant_s;
    logic              drop_s;
    logic [3:0]        sel_dest_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              wb_en_r;
    logic [3:0]        dest_wb_r;
    logic [DATA_W-1:0] result_wb_r;

    // Grant decision: at most one port, nothing during stall or reset.
    always_comb begin
        g0_s = 1'b0;
        g1_s = 1'b0;
        if (rst || stall) begin
            g0_s = 1'b0;
            g1_s = 1'b0;
        end else begin
            case ({bus.v1, bus.v0})
                2'b01: g0_s = 1'b1;
                2'b10: g1_s = 1'b1;
                2'b11: begin
                    // Port 1 overrides only after waiting the full budget.
                    if (wait1_r == MAX_WAIT_C) begin
                        g1_s = 1'b1;
                    end else begin
                        g0_s = 1'b1;
                    end
                end
                default: begin
                    g0_s = 1'b0;
                    g1_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.rdy0 = g0_s;
    assign bus.rdy1 = g1_s;
    assign grant_s  = g0_s | g1_s;

    // Mux the winning request onto the write path.
    always_comb begin
        sel_dest_s = bus.dest0;
        sel_data_s = bus.data0;
        if (g1_s) begin
            sel_dest_s = bus.dest1;
            sel_data_s = bus.data1;
        end else begin
            sel_dest_s = bus.dest0;
            sel_data_s = bus.data0;
        end
    end

`ifdef RF_ARB_DEST_GUARD_EN
    // r15 has no physical register: consume the request but suppress the write.
    assign drop_s = grant_s && (sel_dest_s == DEST_NONE);
`else
    assign drop_s = 1'b0;
`endif

    // Starvation counter for port 1; stall freezes it, a grant or idle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait1_r <= 4'd0;
        end else if (stall) begin
            wait1_r <= wait1_r;
        end else if (!bus.v1 || g1_s) begin
            wait1_r <= 4'd0;
        end else if (wait1_r != MAX_WAIT_C) begin
            wait1_r <= wait1_r + 4'd1;
        end else begin
            wait1_r <= wait1_r;
        end
    end

    // Registered write port; address/data hold their last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_r     <= 1'b0;
            dest_wb_r   <= 4'd0;
            result_wb_r <= '0;
        end else begin
            wb_en_r <= grant_s & ~drop_s;
            if (grant_s && !drop_s) begin
                dest_wb_r   <= sel_dest_s;
                result_wb_r <= sel_data_s;
            end
        end
    end

    assign bus.wb_en     = wb_en_r;
    assign bus.dest_wb   = dest_wb_r;
    assign bus.result_wb = result_wb_r;

`ifdef RF_ARB_DEST_GUARD_EN
    logic err_dest_r;

    // One-cycle error pulse aligned with the suppressed write slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_dest_r <= 1'b0;
        end else begin
            err_dest_r <= drop_s;
        end
    end

    assign bus.err_dest = err_dest_r;
`else
    assign bus.err_dest = 1'b0;
`endif

endmodule
